// File: rtl/bus_transfer_sequencer.sv
// ============================================================================
// Module   : bus_transfer_sequencer
// Brief    : Steps MOVE / ALU / WIDE / NOP commands into per-cycle bus select
//            codes and one-hot register load enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_transfer_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_ra,
    input  logic [3:0]  cmd_rb,
    input  logic [3:0]  cmd_rd,
    input  logic [4:0]  cmd_alu_op,
    output logic [5:0]  bus_sel,
    output logic [15:0] reg_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4
    } state_t;

    localparam logic [1:0] OP_MOVE = 2'd0;
    localparam logic [1:0] OP_ALU  = 2'd1;
    localparam logic [1:0] OP_WIDE = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    localparam logic [5:0] SEL_ZHI = 6'd18;
    localparam logic [5:0] SEL_ZLO = 6'd19;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  rd_q, rd_d;
    logic [4:0]  alu_op_q, alu_op_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic [5:0]  bus_sel_q, bus_sel_d;
    logic [15:0] reg_in_q, reg_in_d;
    logic        y_in_q, y_in_d;
    logic        z_in_q, z_in_d;
    logic        hi_in_q, hi_in_d;
    logic        lo_in_q, lo_in_d;
    logic        done_q, done_d;

    // Next state and latched command fields.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d  = S_T1;
                    op_d     = cmd_op;
                    ra_d     = cmd_ra;
                    rb_d     = cmd_rb;
                    rd_d     = cmd_rd;
                    alu_op_d = cmd_alu_op;
                end
            end
            S_T1:    state_d = ((op_q == OP_MOVE) || (op_q == OP_NOP)) ? S_IDLE : S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (op_q == OP_WIDE) ? S_T4 : S_IDLE;
            S_T4:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // and still line up with the cycle that state is active.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        bus_sel_d   = 6'd0;
        reg_in_d    = 16'd0;
        y_in_d      = 1'b0;
        z_in_d      = 1'b0;
        hi_in_d     = 1'b0;
        lo_in_d     = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_T1: begin
                case (op_d)
                    OP_MOVE: begin
                        bus_sel_d = {2'b00, ra_d};
                        reg_in_d  = 16'd1 << rd_d;
                        done_d    = 1'b1;
                    end
                    OP_ALU, OP_WIDE: begin
                        bus_sel_d = {2'b00, ra_d};
                        y_in_d    = 1'b1;
                    end
                    default: done_d = 1'b1;
                endcase
            end
            S_T2: begin
                bus_sel_d = {2'b00, rb_d};
                z_in_d    = 1'b1;
            end
            S_T3: begin
                bus_sel_d = SEL_ZLO;
                if (op_d == OP_ALU) begin
                    reg_in_d = 16'd1 << rd_d;
                    done_d   = 1'b1;
                end else begin
                    lo_in_d  = 1'b1;
                end
            end
            S_T4: begin
                bus_sel_d = SEL_ZHI;
                hi_in_d   = 1'b1;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            ra_q        <= 4'd0;
            rb_q        <= 4'd0;
            rd_q        <= 4'd0;
            alu_op_q    <= 5'd0;
            cmd_ready_q <= 1'b1;
            bus_sel_q   <= 6'd0;
            reg_in_q    <= 16'd0;
            y_in_q      <= 1'b0;
            z_in_q      <= 1'b0;
            hi_in_q     <= 1'b0;
            lo_in_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            cmd_ready_q <= cmd_ready_d;
            bus_sel_q   <= bus_sel_d;
            reg_in_q    <= reg_in_d;
            y_in_q      <= y_in_d;
            z_in_q      <= z_in_d;
            hi_in_q     <= hi_in_d;
            lo_in_q     <= lo_in_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign bus_sel   = bus_sel_q;
    assign reg_in    = reg_in_q;
    assign y_in      = y_in_q;
    assign z_in      = z_in_q;
    assign hi_in     = hi_in_q;
    assign lo_in     = lo_in_q;
    assign alu_op    = alu_op_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
// ============================================================================
// Module   : tb_bus_transfer_sequencer
// Brief    : Directed self-checking bench for bus_transfer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_transfer_sequencer;

    logic        clock;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_ra;
    logic [3:0]  cmd_rb;
    logic [3:0]  cmd_rd;
    logic [4:0]  cmd_alu_op;
    logic [5:0]  bus_sel;
    logic [15:0] reg_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    bus_transfer_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_rd     (cmd_rd),
        .cmd_alu_op (cmd_alu_op),
        .bus_sel    (bus_sel),
        .reg_in     (reg_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs {bus_sel, reg_in, y,z,hi,lo, done, cmd_ready, busy}.
    function automatic logic [31:0] obs_vec();
        return {3'b000, bus_sel, reg_in, y_in, z_in, hi_in, lo_in, done, cmd_ready, busy};
    endfunction

    function automatic logic [31:0] exp_vec(input logic [5:0] sel, input logic [15:0] rin,
                                            input logic [3:0] yzhl, input logic dn,
                                            input logic rdy);
        return {3'b000, sel, rin, yzhl, dn, rdy, ~rdy};
    endfunction

    task automatic expect_cyc(input string tag, input logic [5:0] sel, input logic [15:0] rin,
                              input logic [3:0] yzhl, input logic dn, input logic rdy);
        chk(tag, obs_vec(), exp_vec(sel, rin, yzhl, dn, rdy));
    endtask

    // Presents a command at a falling edge; returns at the falling edge inside T1.
    task automatic issue(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input logic [4:0] aop);
        @(negedge clock);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_ra     = ra;
        cmd_rb     = rb;
        cmd_rd     = rd;
        cmd_alu_op = aop;
        @(negedge clock);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        int accepts;
        int dones;
        logic [19:0] en;

        clear      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_ra     = 4'd0;
        cmd_rb     = 4'd0;
        cmd_rd     = 4'd0;
        cmd_alu_op = 5'd0;
        #3;
        expect_cyc("reset_outputs", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);
        chk("reset_alu_op", {27'd0, alu_op}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;

        // MOVE ra=3 -> rd=7
        issue(2'd0, 4'd3, 4'd0, 4'd7, 5'd0);
        expect_cyc("move_t1", 6'd3, 16'h0080, 4'b0000, 1'b1, 1'b0);
        @(negedge clock);
        expect_cyc("move_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

        // ALU ra=1 rb=2 rd=5 op=0A
        issue(2'd1, 4'd1, 4'd2, 4'd5, 5'h0A);
        expect_cyc("alu_t1", 6'd1, 16'h0000, 4'b1000, 1'b0, 1'b0);
        chk("alu_t1_op", {27'd0, alu_op}, 32'h0A);
        @(negedge clock);
        expect_cyc("alu_t2", 6'd2, 16'h0000, 4'b0100, 1'b0, 1'b0);
        chk("alu_t2_op", {27'd0, alu_op}, 32'h0A);
        @(negedge clock);
        expect_cyc("alu_t3", 6'd19, 16'h0020, 4'b0000, 1'b1, 1'b0);
        chk("alu_t3_op", {27'd0, alu_op}, 32'h0A);
        @(negedge clock);
        expect_cyc("alu_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);
        chk("alu_idle_op_held", {27'd0, alu_op}, 32'h0A);

        // WIDE ra=4 rb=6
        issue(2'd2, 4'd4, 4'd6, 4'd9, 5'h11);
        expect_cyc("wide_t1", 6'd4, 16'h0000, 4'b1000, 1'b0, 1'b0);
        @(negedge clock);
        expect_cyc("wide_t2", 6'd6, 16'h0000, 4'b0100, 1'b0, 1'b0);
        @(negedge clock);
        expect_cyc("wide_t3", 6'd19, 16'h0000, 4'b0001, 1'b0, 1'b0);
        @(negedge clock);
        expect_cyc("wide_t4", 6'd18, 16'h0000, 4'b0010, 1'b1, 1'b0);
        @(negedge clock);
        expect_cyc("wide_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

        // NOP
        issue(2'd3, 4'd8, 4'd8, 4'd8, 5'h02);
        expect_cyc("nop_t1", 6'd0, 16'h0000, 4'b0000, 1'b1, 1'b0);
        @(negedge clock);
        expect_cyc("nop_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

        // ALU with cmd_valid held and fields changing while busy
        issue(2'd1, 4'd1, 4'd2, 4'd3, 5'h03);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd0;
        cmd_ra     = 4'd9;
        cmd_rd     = 4'd10;
        cmd_alu_op = 5'h1F;
        expect_cyc("hold_t1", 6'd1, 16'h0000, 4'b1000, 1'b0, 1'b0);
        chk("hold_t1_op", {27'd0, alu_op}, 32'h03);
        @(negedge clock);
        cmd_ra = 4'd12;
        expect_cyc("hold_t2", 6'd2, 16'h0000, 4'b0100, 1'b0, 1'b0);
        @(negedge clock);
        cmd_ra = 4'd9;
        expect_cyc("hold_t3", 6'd19, 16'h0008, 4'b0000, 1'b1, 1'b0);
        chk("hold_t3_op", {27'd0, alu_op}, 32'h03);
        @(negedge clock);
        expect_cyc("hold_gap_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b0;
        expect_cyc("hold_next_move", 6'd9, 16'h0400, 4'b0000, 1'b1, 1'b0);
        chk("hold_next_op", {27'd0, alu_op}, 32'h1F);
        @(negedge clock);

        // Clear during WIDE T2
        issue(2'd2, 4'd4, 4'd6, 4'd2, 5'h07);
        expect_cyc("clr_wide_t1", 6'd4, 16'h0000, 4'b1000, 1'b0, 1'b0);
        @(negedge clock);
        expect_cyc("clr_wide_t2", 6'd6, 16'h0000, 4'b0100, 1'b0, 1'b0);
        #1;
        clear = 1'b1;
        #1;
        expect_cyc("clr_async", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);
        chk("clr_alu_op", {27'd0, alu_op}, 32'd0);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd0;
        cmd_ra     = 4'd5;
        cmd_rd     = 4'd1;
        cmd_alu_op = 5'h04;
        @(negedge clock);
        expect_cyc("clr_held_no_accept", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);
        clear = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        expect_cyc("clr_after_move", 6'd5, 16'h0002, 4'b0000, 1'b1, 1'b0);
        @(negedge clock);
        expect_cyc("clr_after_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

        // Random command stream
        accepts = 0;
        dones   = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            en = {reg_in, y_in, z_in, hi_in, lo_in};
            chk("rand_onehot0", {31'd0, $onehot0(en)}, 32'd1);
            chk("rand_sel_range", {31'd0, (bus_sel <= 6'd23)}, 32'd1);
            if (done) dones++;
            cmd_valid  = ($urandom_range(0, 3) != 0);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_ra     = 4'($urandom_range(0, 15));
            cmd_rb     = 4'($urandom_range(0, 15));
            cmd_rd     = 4'($urandom_range(0, 15));
            cmd_alu_op = 5'($urandom_range(0, 31));
            if (cmd_valid && cmd_ready) accepts++;
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("rand_done_count", dones, accepts);
        expect_cyc("rand_final_idle", 6'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
